// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and phase-sequencing helpers for the traffic controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package traffic_pkg;

    // Phase codes in sequence order; codes 6 and 7 are unused and treated as illegal.
    typedef enum logic [2:0] {
        PH_NS_GREEN  = 3'd0,
        PH_NS_YELLOW = 3'd1,
        PH_ALL_RED_A = 3'd2,
        PH_EW_GREEN  = 3'd3,
        PH_EW_YELLOW = 3'd4,
        PH_ALL_RED_B = 3'd5
    } phase_t;

    // Lamp encodings, {R,Y,G} one-hot.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamps_t;

    // Successor in the fixed cycle; illegal codes recover into the EW->NS clearance phase.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_NS_GREEN:  return PH_NS_YELLOW;
            PH_NS_YELLOW: return PH_ALL_RED_A;
            PH_ALL_RED_A: return PH_EW_GREEN;
            PH_EW_GREEN:  return PH_EW_YELLOW;
            PH_EW_YELLOW: return PH_ALL_RED_B;
            PH_ALL_RED_B: return PH_NS_GREEN;
            default:      return PH_ALL_RED_B;
        endcase
    endfunction

    // Lamp decode; anything not explicitly a go/caution phase shows red both ways.
    function automatic lamps_t lamps_of(input phase_t p);
        lamps_t l;
        l.ns = LAMP_RED;
        l.ew = LAMP_RED;
        case (p)
            PH_NS_GREEN:  l.ns = LAMP_GRN;
            PH_NS_YELLOW: l.ns = LAMP_YEL;
            PH_EW_GREEN:  l.ew = LAMP_GRN;
            PH_EW_YELLOW: l.ew = LAMP_YEL;
            default:      l = '{ns: LAMP_RED, ew: LAMP_RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Turns the divider's slow square wave into a one-clk tick on each rising edge.
// Latency: combinational tick, valid in the clk cycle where enable is first seen high.
// Backpressure: none; enable held high yields a single tick.
module tick_edge_detect (
    input  logic clk,
    input  logic reset_sync,
    input  logic enable,
    output logic tick
);

    logic enable_q;

    // Previous enable level; resets high to match the divider so reset never fakes an edge.
    always_ff @(posedge clk or posedge reset_sync) begin
        if (reset_sync) begin
            enable_q <= 1'b1;
        end else begin
            enable_q <= enable;
        end
    end

    assign tick = enable & ~enable_q;

endmodule

// File: rtl/traffic_phase_fsm.sv
// Two-direction traffic phase sequencer with per-phase countdown; optional pedestrian shortening under PED_REQ_EN.
// Latency: phase, lamps and secs_left update on the clk edge that samples the enable rising edge.
// Backpressure: none; free-running, ped_req is latched until the next green serves it.
module traffic_phase_fsm
    import traffic_pkg::*;
#(
    parameter int NS_GREEN_S = 10,
    parameter int EW_GREEN_S = 10,
    parameter int YELLOW_S   = 3,
    parameter int ALL_RED_S  = 1,
    parameter int CNT_W      = 5,
    parameter int PED_MIN_S  = 3
) (
    input  logic             clk,
    input  logic             reset_sync,
    input  logic             enable,
`ifdef PED_REQ_EN
    input  logic             ped_req,
    output logic             ped_ack,
`endif
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] secs_left
);

    localparam int CNT_LIM = 1 << CNT_W;

    // Every duration has to fit the countdown and last at least one tick.
    if (NS_GREEN_S < 1 || NS_GREEN_S >= CNT_LIM ||
        EW_GREEN_S < 1 || EW_GREEN_S >= CNT_LIM ||
        YELLOW_S   < 1 || YELLOW_S   >= CNT_LIM ||
        ALL_RED_S  < 1 || ALL_RED_S  >= CNT_LIM ||
        PED_MIN_S  < 1 || PED_MIN_S  >= CNT_LIM) begin : g_bad_duration
        $error("traffic_phase_fsm: every duration must lie in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] D_NS_GREEN = CNT_W'(NS_GREEN_S);
    localparam logic [CNT_W-1:0] D_EW_GREEN = CNT_W'(EW_GREEN_S);
    localparam logic [CNT_W-1:0] D_YELLOW   = CNT_W'(YELLOW_S);
    localparam logic [CNT_W-1:0] D_ALL_RED  = CNT_W'(ALL_RED_S);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    function automatic logic [CNT_W-1:0] dur_of(input phase_t p);
        case (p)
            PH_NS_GREEN:                return D_NS_GREEN;
            PH_EW_GREEN:                return D_EW_GREEN;
            PH_NS_YELLOW, PH_EW_YELLOW: return D_YELLOW;
            default:                    return D_ALL_RED;
        endcase
    endfunction

    logic             tick;
    phase_t           state_q;
    phase_t           state_d;
    logic [CNT_W-1:0] secs_q;
    logic [CNT_W-1:0] secs_d;
    lamps_t           lamps;

    tick_edge_detect u_tick (
        .clk        (clk),
        .reset_sync (reset_sync),
        .enable     (enable),
        .tick       (tick)
    );

`ifdef PED_REQ_EN
    localparam logic [CNT_W-1:0] D_PED_MIN = CNT_W'(PED_MIN_S);

    logic in_green;
    logic ped_seen;
    logic ped_trunc;
    logic ped_pending_q;
    logic ped_pending_d;
    logic ped_ack_q;
    logic ped_ack_d;

    // A request is served (acked, and the green shortened if needed) the first cycle it meets a green.
    always_comb begin
        in_green      = (state_q == PH_NS_GREEN) || (state_q == PH_EW_GREEN);
        ped_seen      = ped_pending_q | ped_req;
        ped_trunc     = in_green & ped_seen & (secs_q > D_PED_MIN);
        ped_ack_d     = in_green & ped_seen;
        ped_pending_d = ped_seen & ~in_green;
    end

    // Pending flag and one-clk acknowledge pulse.
    always_ff @(posedge clk or posedge reset_sync) begin
        if (reset_sync) begin
            ped_pending_q <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            ped_ack_q     <= ped_ack_d;
        end
    end

    assign ped_ack = ped_ack_q;
`endif

    // Countdown and phase advance; an illegal code snaps back to the clearance phase.
    always_comb begin
        state_d = state_q;
        secs_d  = secs_q;
        case (state_q)
            PH_NS_GREEN, PH_NS_YELLOW, PH_ALL_RED_A,
            PH_EW_GREEN, PH_EW_YELLOW, PH_ALL_RED_B: begin
                if (tick) begin
                    if (secs_q > ONE) begin
                        secs_d = secs_q - ONE;
                    end else begin
                        state_d = next_phase(state_q);
                        secs_d  = dur_of(next_phase(state_q));
                    end
                end
            end
            default: begin
                state_d = PH_ALL_RED_B;
                secs_d  = D_ALL_RED;
            end
        endcase
`ifdef PED_REQ_EN
        // Shortening takes priority over a coincident decrement.
        if (ped_trunc) begin
            secs_d = D_PED_MIN;
        end
`endif
    end

    // Phase and countdown registers; reset parks in all-red clearance ahead of NS green.
    always_ff @(posedge clk or posedge reset_sync) begin
        if (reset_sync) begin
            state_q <= PH_ALL_RED_B;
            secs_q  <= D_ALL_RED;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
        end
    end

    assign lamps     = lamps_of(state_q);
    assign ns_light  = lamps.ns;
    assign ew_light  = lamps.ew;
    assign phase     = state_q;
    assign secs_left = secs_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Bench for traffic_phase_fsm: cycle-by-cycle reference model plus directed literal checks.
// Latency: model and DUT both update on the clk edge that samples an enable rise.
// Backpressure: not applicable.
module tb_traffic_phase_fsm;

    localparam int NS_G  = 4;
    localparam int EW_G  = 3;
    localparam int YEL   = 2;
    localparam int ARED  = 1;
    localparam int CW    = 5;
    localparam int PEDMN = 2;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          ped_req;
    logic          ped_ack;
    logic [2:0]    ns_light;
    logic [2:0]    ew_light;
    logic [2:0]    phase;
    logic [CW-1:0] secs_left;

    int n_cmp;
    int n_bad;
    int chg_cnt;
    logic chk_en;

    traffic_phase_fsm #(
        .NS_GREEN_S (NS_G),
        .EW_GREEN_S (EW_G),
        .YELLOW_S   (YEL),
        .ALL_RED_S  (ARED),
        .CNT_W      (CW),
        .PED_MIN_S  (PEDMN)
    ) dut (
        .clk        (clk),
        .reset_sync (rst),
        .enable     (enable),
`ifdef PED_REQ_EN
        .ped_req    (ped_req),
        .ped_ack    (ped_ack),
`endif
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .phase      (phase),
        .secs_left  (secs_left)
    );

`ifndef PED_REQ_EN
    assign ped_ack = 1'b0;
`endif

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int dur(input int p);
        case (p)
            0:       return NS_G;
            1, 4:    return YEL;
            3:       return EW_G;
            default: return ARED;
        endcase
    endfunction

    function automatic logic [2:0] ns_of(input int p);
        case (p)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_of(input int p);
        case (p)
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    int   m_phase;
    int   m_left;
    logic m_prev;
    logic m_pend;
    logic m_ack;
    logic m_tick;
    logic m_green;
    logic m_seen;

    assign m_tick  = enable && !m_prev;
    assign m_green = (m_phase == 0) || (m_phase == 3);
    assign m_seen  = m_pend || ped_req;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 5;
            m_left  <= ARED;
            m_prev  <= 1'b1;
            m_pend  <= 1'b0;
            m_ack   <= 1'b0;
        end else begin
            m_prev <= enable;
`ifdef PED_REQ_EN
            m_ack  <= m_green && m_seen;
            m_pend <= m_seen && !m_green;
            if (m_green && m_seen && m_left > PEDMN) m_left <= PEDMN;
            else
`endif
            if (m_tick) begin
                if (m_left > 1) begin
                    m_left <= m_left - 1;
                end else begin
                    m_phase <= (m_phase + 1) % 6;
                    m_left  <= dur((m_phase + 1) % 6);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus the never-both-non-red invariant.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("model_phase", int'(phase), m_phase);
            chk("model_secs", int'(secs_left), m_left);
            chk("model_ns", int'(ns_light), int'(ns_of(m_phase)));
            chk("model_ew", int'(ew_light), int'(ew_of(m_phase)));
            chk("safety_both_go", int'(ns_light != 3'b100 && ew_light != 3'b100), 0);
`ifdef PED_REQ_EN
            chk("model_ped_ack", int'(ped_ack), int'(m_ack));
`endif
        end
    end

    // ---------------- stimulus ----------------
    int exp_ph [13] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
    int exp_s  [13] = '{3, 2, 1, 2, 1, 1, 3, 2, 1, 2, 1, 1, 4};

    task automatic do_tick();
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_sequence();
        do_tick();
        chk("entry_phase", int'(phase), 0);
        chk("entry_ns", int'(ns_light), 1);
        chk("entry_ew", int'(ew_light), 4);
        chk("entry_secs", int'(secs_left), 4);
        for (int k = 0; k < 13; k++) begin
            do_tick();
            chk("seq_phase", int'(phase), exp_ph[k]);
            chk("seq_secs", int'(secs_left), exp_s[k]);
        end
    endtask

    task automatic hold_count(input logic val, input int n);
        logic [7:0] prev;
        enable = val;
        for (int i = 0; i < n; i++) begin
            prev = {phase, secs_left};
            @(negedge clk);
            if ({phase, secs_left} != prev) chg_cnt++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_phase"}, int'(phase), 5);
        chk({tag, "_ns"}, int'(ns_light), 4);
        chk({tag, "_ew"}, int'(ew_light), 4);
        chk({tag, "_secs"}, int'(secs_left), 1);
        chk({tag, "_ack"}, int'(ped_ack), 0);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        chg_cnt = 0;
        chk_en  = 1'b0;
        clk     = 1'b0;
        rst     = 1'b0;
        enable  = 1'b1;
        ped_req = 1'b0;
        #1 rst = 1'b1;
        #2 chk_reset_outputs("in_reset");
        #20 rst = 1'b0;
        chk_en = 1'b1;

        // Scenario 1: enable high after reset gives no tick.
        repeat (3) @(negedge clk);
        chk_reset_outputs("post_reset_no_tick");

        // Scenarios 1+2: first tick enters NS green, then one full cycle.
        run_sequence();

        // Scenario 3: long-held enable counts once.
        hold_count(1'b0, 4);
        hold_count(1'b1, 40);
        hold_count(1'b0, 4);
        hold_count(1'b1, 4);
        chk("held_enable_ticks", chg_cnt, 2);
        chk("held_enable_secs", int'(secs_left), 2);

        // Scenario 4: reset in the middle of EW green.
        for (int i = 0; i < 20 && !(m_phase == 3 && m_left == 2); i++) do_tick();
        chk("pre_reset_phase", int'(phase), 3);
        chk("pre_reset_secs", int'(secs_left), 2);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_reset");
        @(negedge clk);
        #2 rst = 1'b0;
        run_sequence();

        // Scenario 5: illegal phase code recovers to clearance on the next clk.
        chk_en = 1'b0;
        @(negedge clk);
        force dut.state_q = traffic_pkg::phase_t'(3'd7);
        #1;
        chk("illegal_phase_seen", int'(phase), 7);
        chk("illegal_ns_red", int'(ns_light), 4);
        chk("illegal_ew_red", int'(ew_light), 4);
        @(posedge clk);
        #1;
        chk("illegal_secs_reload", int'(secs_left), 1);
        release dut.state_q;
        chk("illegal_ns_red2", int'(ns_light), 4);
        chk("illegal_ew_red2", int'(ew_light), 4);
        @(posedge clk);
        #1;
        chk("recover_phase", int'(phase), 5);
        chk("recover_secs", int'(secs_left), 1);
        chk("recover_ns", int'(ns_light), 4);
        chk("recover_ew", int'(ew_light), 4);
        #1 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;

`ifdef PED_REQ_EN
        // Scenario 6: pedestrian request shortens NS green to PED_MIN_S.
        do_tick();
        chk("ped_pre_phase", int'(phase), 0);
        chk("ped_pre_secs", int'(secs_left), 4);
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        chk("ped_trunc_secs", int'(secs_left), 2);
        chk("ped_ack_pulse", int'(ped_ack), 1);
        @(negedge clk);
        chk("ped_ack_drop", int'(ped_ack), 0);
        do_tick();
        chk("ped_tick1_phase", int'(phase), 0);
        chk("ped_tick1_secs", int'(secs_left), 1);
        do_tick();
        chk("ped_yellow_phase", int'(phase), 1);
        chk("ped_yellow_secs", int'(secs_left), 2);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/traffic_phase_fsm.md
Name: traffic_phase_fsm

Overview:
- Traffic-light phase controller that consumes the slow square-wave `enable` produced by the clock divider.
- Detects each rising edge of `enable` as a one-second tick.
- Sequences two crossing directions (NS/EW) through green, yellow and all-red phases, with a per-phase countdown.
- Drives the lamp outputs and a seconds-remaining value for the display stage downstream.

Parameters:
- NS_GREEN_S, 10, NS green duration in ticks (>=1)
- EW_GREEN_S, 10, EW green duration in ticks (>=1)
- YELLOW_S, 3, yellow duration in ticks, both directions (>=1)
- ALL_RED_S, 1, all-red clearance duration in ticks (>=1)
- CNT_W, 5, width of the countdown; every duration must be < 2**CNT_W (elaboration-time check)
- PED_MIN_S, 3, remaining green after a pedestrian request (used only with PED_REQ_EN; 1 <= PED_MIN_S)

Ports:
- clk  input  1  system clock
- reset_sync  input  1  asynchronous, active-high reset
- enable  input  1  divider square wave; rising edge = one tick
- ns_light  output  3  NS lamps {R,Y,G}, one-hot
- ew_light  output  3  EW lamps {R,Y,G}, one-hot
- phase  output  3  current phase code
- secs_left  output  CNT_W  ticks remaining in current phase

Behaviour:
- Interface: one clock, `clk`. Reset `reset_sync` is asynchronous and active-high.
- Edge detection: register `enable_q` resets to 1, because the divider resets `enable` to 1; no false tick follows reset.
  - `tick = enable & ~enable_q`, combinational.
  - `enable` held high for any length yields exactly one tick.
- Phases and codes, in order: NS_GREEN(0) -> NS_YELLOW(1) -> ALL_RED_A(2) -> EW_GREEN(3) -> EW_YELLOW(4) -> ALL_RED_B(5) -> NS_GREEN. Codes 6 and 7 are unused.
- Lamps per phase:
  - NS_GREEN: NS=001, EW=100.
  - NS_YELLOW: NS=010, EW=100.
  - ALL_RED_A and ALL_RED_B: both 100.
  - EW_GREEN: NS=100, EW=001.
  - EW_YELLOW: NS=100, EW=010.
- Countdown:
  - On entry to a phase, `secs_left` loads that phase's duration.
  - On each tick with `secs_left` > 1, `secs_left` decrements.
  - On a tick with `secs_left` == 1, the block advances to the next phase and loads the next duration in the same edge.
  - Each phase therefore lasts exactly its duration in ticks.
- Latency: all outputs are registered and Moore-style. They change on the same `clk` edge at which `enable`=1 and `enable_q`=0 are sampled.
- Reset values (asynchronous, immediate): phase=5 (ALL_RED_B), ns_light=100, ew_light=100, secs_left=ALL_RED_S, enable_q=1.
  - The first tick after reset, when ALL_RED_S=1, enters NS_GREEN.
- Reset mid-phase: outputs go to the reset values asynchronously; the countdown is discarded.
- Illegal phase code (6/7, e.g. after an upset): on the next clk, phase=5 with secs_left=ALL_RED_S, tick or no tick. Lamps decode to all-red for any illegal code.
- Safety invariant: at no cycle are both directions non-red.

Optional Feature:
- Macro: PED_REQ_EN.
- When defined, the block adds:
  - input `ped_req` (1, synchronous level/pulse);
  - output `ped_ack` (1, one-clk pulse);
  - an internal `ped_pending` flag, which resets to 0.
- `ped_req`=1 sets `ped_pending`.
- While in NS_GREEN or EW_GREEN with `ped_pending`=1:
  - If `secs_left` > PED_MIN_S, `secs_left` is loaded with PED_MIN_S on the next clk, `ped_pending` clears, and `ped_ack` pulses.
  - If `secs_left` <= PED_MIN_S, `ped_pending` clears and `ped_ack` pulses without shortening.
- When a tick and a truncation coincide, truncation wins and the decrement is skipped that edge.
- A request arriving outside a green phase stays pending until the next green.
- When not defined: no extra ports, no flag; greens always run full length.

Decomposition:
- Shared package `traffic_pkg`:
  - phase codes as localparams or enum (`PH_NS_GREEN`..`PH_ALL_RED_B`);
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001.
- One sub-module, `tick_edge_detect`: input clk, reset_sync, enable; output tick. Its register resets to 1.
- FSM, countdown and lamp decode stay in `traffic_phase_fsm`.

Test Plan:
Parameters for all scenarios: NS_GREEN_S=4, EW_GREEN_S=3, YELLOW_S=2, ALL_RED_S=1; `enable` toggles every 4 clk, giving one tick per 8 clk.
1. Release reset with `enable`=1 -> no tick before the first 0->1 edge; outputs hold phase=5, lamps 100/100, secs_left=1. The first tick gives phase=0, NS=001, secs_left=4.
2. Run 13 ticks from NS_GREEN entry -> phase sequence 0,1,2,3,4,5,0 with dwell 4,2,1,3,2,1 ticks; secs_left counts 4,3,2,1 in NS_GREEN. A monitor checks that both directions are never non-red.
3. Hold `enable`=1 for 40 clk, then drop and re-raise it -> exactly 2 ticks counted.
4. Assert reset_sync mid-EW_GREEN with secs_left=2 -> outputs go to 5/100/100/1 without waiting for clk; after release the sequence restarts as in scenario 2.
5. Force phase=7 via the bench -> next clk phase=5, secs_left=1, lamps all-red throughout.
6. PED_REQ_EN defined, `ped_req` pulse at NS_GREEN with secs_left=4, PED_MIN_S=2 -> next clk secs_left=2 and `ped_ack`=1 for one clk; NS_YELLOW is entered 2 ticks later.
